aes_key_expand: RTL



---
 rtl/aes_key_expand.sv | 109 ++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand: sequential AES-128 key schedule, one round key per clock,
// each key streamed out and kept in an 11-entry buffer for random-access readback.
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [0:127] round_key,
    output logic         done,
    output logic         keys_ready,
    input  logic [3:0]   rd_sel,
    output logic [0:127] rd_key
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    typedef enum logic {IDLE, EXPAND} state_t;
    state_t       state;
    logic [0:127] key_buf [0:NR];
    logic [0:31]  w3, t, w0n, w1n, w2n, w3n;
    logic [0:127] next_key;
    // Byte S-box behind the shared 32-bit lookup interface: byte in the low 8 bits.
    function automatic logic [31:0] sbox_lookup(input logic [31:0] x);
        return {24'h0, SBOX[{x[7:0], 3'b000} +: 8]};
    endfunction
    function automatic logic [0:31] sub_word(input logic [0:31] w);
        logic [31:0] s0, s1, s2, s3;
        s0 = sbox_lookup({24'h0, w[0:7]});
        s1 = sbox_lookup({24'h0, w[8:15]});
        s2 = sbox_lookup({24'h0, w[16:23]});
        s3 = sbox_lookup({24'h0, w[24:31]});
        return {s0[7:0], s1[7:0], s2[7:0], s3[7:0]};
    endfunction
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:  return 8'h01;
            4'd2:  return 8'h02;
            4'd3:  return 8'h04;
            4'd4:  return 8'h08;
            4'd5:  return 8'h10;
            4'd6:  return 8'h20;
            4'd7:  return 8'h40;
            4'd8:  return 8'h80;
            4'd9:  return 8'h1b;
            4'd10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction
    always_comb begin
        w3       = round_key[96:127];
        t        = sub_word({w3[8:31], w3[0:7]}) ^ {rcon(rk_idx + 4'd1), 24'h0};
        w0n      = round_key[0:31] ^ t;
        w1n      = round_key[32:63] ^ w0n;
        w2n      = round_key[64:95] ^ w1n;
        w3n      = w3 ^ w2n;
        next_key = {w0n, w1n, w2n, w3n};
    end
    // round_key doubles as the working register; rk_idx doubles as the round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            rk_valid   <= 1'b0;
            rk_idx     <= '0;
            round_key  <= '0;
            done       <= 1'b0;
            keys_ready <= 1'b0;
            for (int i = 0; i <= NR; i++) key_buf[i] <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                state      <= EXPAND;
                busy       <= 1'b1;
                rk_valid   <= 1'b1;
                rk_idx     <= '0;
                round_key  <= key_in;
                keys_ready <= 1'b0;
            end
        end else begin
            key_buf[rk_idx] <= round_key;
            if (rk_idx == 4'(NR)) begin
                state      <= IDLE;
                busy       <= 1'b0;
                rk_valid   <= 1'b0;
                done       <= 1'b0;
                keys_ready <= 1'b1;
            end else begin
                round_key <= next_key;
                rk_idx    <= rk_idx + 4'd1;
                done      <= rk_idx == 4'(NR - 1);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_key <= '0;
        else        rd_key <= (rd_sel > 4'(NR)) ? '0 : key_buf[rd_sel];
    end
endmodule
